// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: fetch and program-loader signals between imem_ctrl and its
// neighbours (ifetch on the fetch side, a byte-stream source on the load side).
//   master: drives inst_addr, run_req, ld_start, ld_len, ld_valid, ld_data;
//           receives inst_data, inst_valid, cpu_reset_, ld_ready, ld_done, ld_csum.
//   slave:  the instruction-memory controller (opposite directions).
interface imem_ctrl_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_data;
    logic              inst_valid;
    logic              cpu_reset_;
    logic              run_req;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic [DATA_W-1:0] ld_csum;

    modport master (
        output inst_addr, run_req, ld_start, ld_len, ld_valid, ld_data,
        input  inst_data, inst_valid, cpu_reset_, ld_ready, ld_done, ld_csum
    );

    modport slave (
        input  inst_addr, run_req, ld_start, ld_len, ld_valid, ld_data,
        output inst_data, inst_valid, cpu_reset_, ld_ready, ld_done, ld_csum
    );
endinterface

// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory for the 8-bit core with a byte-stream loader.
// The loader fills memory from address 0 while the core is held in reset, then
// the block switches to RUN and answers one fetch per cycle with 1-cycle latency.
// Ports:
//   clk     - core clock
//   reset_  - synchronous active-low reset (memory contents are kept)
//   bus     - imem_ctrl_if.slave: fetch address/data/valid, cpu_reset_,
//             run_req, and the ld_* loader handshake with running checksum
module imem_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic        clk,
    input  logic        reset_,
    imem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [DATA_W-1:0] ld_csum_q, ld_csum_d;
    logic [DATA_W-1:0] inst_data_q;
    logic              inst_valid_q;
    logic              cpu_reset_q;
    logic              ld_accept;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_cnt_d  = ld_cnt_q;
        ld_csum_d = ld_csum_q;
        ld_accept = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ld_start wins over run_req when both arrive together
                if (bus.ld_start) begin
                    state_d   = StLoad;
                    ld_addr_d = '0;
                    ld_cnt_d  = bus.ld_len;
                    ld_csum_d = '0;
                end else if (bus.run_req) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                if (bus.ld_valid) begin
                    ld_accept = 1'b1;
                    ld_addr_d = ld_addr_q + ADDR_W'(1);
                    ld_csum_d = ld_csum_q + bus.ld_data;
                    if (ld_addr_q == ld_cnt_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q      <= StIdle;
            ld_addr_q    <= '0;
            ld_cnt_q     <= '0;
            ld_csum_q    <= '0;
            inst_data_q  <= '0;
            inst_valid_q <= 1'b0;
            cpu_reset_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_csum_q   <= ld_csum_d;
            // Released on the edge that enters RUN, so the core's first cycle
            // out of reset is also the first cycle its fetch address is sampled.
            cpu_reset_q <= (state_d == StRun);
            if (state_q == StRun) begin
                inst_data_q  <= mem[bus.inst_addr];
                inst_valid_q <= 1'b1;
            end else begin
                inst_valid_q <= 1'b0;
            end
        end
    end

    // Separate write port without reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (reset_ && ld_accept) begin
            mem[ld_addr_q] <= bus.ld_data;
        end
    end

    assign bus.inst_data  = inst_data_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.cpu_reset_ = cpu_reset_q;
    assign bus.ld_ready   = (state_q == StLoad);
    assign bus.ld_done    = (state_q == StDone);
    assign bus.ld_csum    = ld_csum_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: directed scenarios plus randomized loads
// and fetches, checked against a byte-array model of the memory contents.
module tb_imem_ctrl;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4096;

    logic clk    = 1'b0;
    logic reset_ = 1'b0;

    imem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] model_mem [DEPTH];

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d errors=%0d", vectors, errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_addr = '0;
        bus.run_req   = 1'b0;
        bus.ld_start  = 1'b0;
        bus.ld_len    = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
    endtask

    task automatic apply_reset(input int n);
        idle_inputs();
        reset_ = 1'b0;
        repeat (n) step();
        reset_ = 1'b1;
    endtask

    // Drives a complete load from IDLE and records what it observed; callers judge.
    task automatic load_stream(input int len_m1, input logic [7:0] bytes[$], input int gap_max,
                               output int ready_miss, output int early_done,
                               output logic done_pulse, output logic [7:0] csum_at_done,
                               output logic cpu_at_done, output logic cpu_after);
        int g;
        ready_miss = 0;
        early_done = 0;
        bus.ld_len   = 12'(len_m1);
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i <= len_m1; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int k = 0; k < g; k++) begin
                bus.ld_valid = 1'b0;
                bus.ld_data  = 8'($urandom);
                if (bus.ld_ready !== 1'b1) ready_miss++;
                if (bus.ld_done !== 1'b0) early_done++;
                step();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = bytes[i];
            if (bus.ld_ready !== 1'b1) ready_miss++;
            if (bus.ld_done !== 1'b0) early_done++;
            step();
            model_mem[i] = bytes[i];
        end
        bus.ld_valid = 1'b0;
        done_pulse   = bus.ld_done;
        csum_at_done = bus.ld_csum;
        cpu_at_done  = bus.cpu_reset_;
        step();
        cpu_after = bus.cpu_reset_;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        apply_reset(3);
        obs = {bus.inst_data, bus.inst_valid, bus.ld_ready, bus.ld_done, bus.ld_csum,
               bus.cpu_reset_};
        vectors++;
        if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 00000", obs);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            obs = {bus.inst_data, bus.inst_valid, bus.ld_ready, bus.ld_done, bus.ld_csum,
                   bus.cpu_reset_};
            vectors++;
            if (obs !== 20'h0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got %h, want 00000", c, obs);
            end
        end
    endtask

    task automatic test_small_load();
        logic [7:0] q[$];
        int rm, ed;
        logic dp, ca, cf;
        logic [7:0] cs;
        q = '{8'h11, 8'h22, 8'h33, 8'hF0};
        load_stream(3, q, 0, rm, ed, dp, cs, ca, cf);
        vectors++;
        if (rm != 0) begin errors++; $display("FAIL small_ready: %0d cycles low, want 0", rm); end
        vectors++;
        if (ed != 0) begin errors++; $display("FAIL small_early_done: %0d, want 0", ed); end
        vectors++;
        if (dp !== 1'b1) begin errors++; $display("FAIL small_done: got %b, want 1", dp); end
        vectors++;
        if (cs !== 8'h56) begin errors++; $display("FAIL small_csum: got %h, want 56", cs); end
        vectors++;
        if (ca !== 1'b0) begin errors++; $display("FAIL small_cpu_at_done: got %b, want 0", ca); end
        vectors++;
        if (cf !== 1'b1) begin errors++; $display("FAIL small_cpu_after: got %b, want 1", cf); end
        vectors++;
        if (bus.ld_done !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL small_run_entry: done=%b valid=%b, want 0 0", bus.ld_done,
                     bus.inst_valid);
        end
    endtask

    task automatic test_fetch();
        logic [11:0] a;
        for (int i = 0; i < 4 + 12; i++) begin
            a = (i < 4) ? 12'(i) : 12'($urandom_range(0, 3));
            bus.inst_addr = a;
            step();
            vectors++;
            if (bus.inst_valid !== 1'b1 || bus.inst_data !== model_mem[a]) begin
                errors++;
                $display("FAIL fetch addr %h: got valid=%b data=%h, want 1 %h", a,
                         bus.inst_valid, bus.inst_data, model_mem[a]);
            end
        end
        reset_ = 1'b0;
        step();
        vectors++;
        if (bus.inst_valid !== 1'b0 || bus.cpu_reset_ !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run: valid=%b cpu_reset_=%b, want 0 0", bus.inst_valid,
                     bus.cpu_reset_);
        end
        apply_reset(1);
    endtask

    task automatic test_stalled();
        bit         v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] d [2] = '{8'hA5, 8'h5A};
        logic [7:0] exp_csum = 8'h00;
        int         n = 0;
        bus.ld_len   = 12'd1;
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.ld_valid = v[s];
            bus.ld_data  = v[s] ? d[n] : 8'($urandom);
            vectors++;
            if (bus.ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready slot %0d: got %b, want 1", s, bus.ld_ready);
            end
            step();
            if (v[s]) begin
                model_mem[n] = d[n];
                exp_csum     = exp_csum + d[n];
                n++;
            end
            if (s < 3) begin
                vectors++;
                if (bus.ld_csum !== exp_csum || bus.ld_done !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_gap slot %0d: csum=%h done=%b, want %h 0", s,
                             bus.ld_csum, bus.ld_done, exp_csum);
                end
            end
        end
        bus.ld_valid = 1'b0;
        vectors++;
        if (bus.ld_done !== 1'b1 || bus.ld_csum !== 8'hFF) begin
            errors++;
            $display("FAIL stall_done: done=%b csum=%h, want 1 FF", bus.ld_done, bus.ld_csum);
        end
        step();
        for (int a = 0; a < 3; a++) begin
            bus.inst_addr = 12'(a);
            step();
            vectors++;
            if (bus.inst_data !== model_mem[a]) begin
                errors++;
                $display("FAIL stall_fetch addr %0d: got %h, want %h", a, bus.inst_data,
                         model_mem[a]);
            end
        end
        apply_reset(2);
    endtask

    task automatic test_abort_priority();
        logic [7:0] d [2] = '{8'h3C, 8'hC3};
        logic [7:0] e [2] = '{8'h70, 8'h81};
        bus.ld_len   = 12'd4;
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = d[i];
            step();
            model_mem[i] = d[i];
        end
        bus.ld_valid = 1'b0;
        reset_ = 1'b0;
        step();
        vectors++;
        if (bus.ld_done !== 1'b0 || bus.ld_csum !== 8'h00 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: done=%b csum=%h ready=%b, want 0 00 0", bus.ld_done,
                     bus.ld_csum, bus.ld_ready);
        end
        step();
        reset_ = 1'b1;
        step();
        vectors++;
        if (bus.ld_done !== 1'b0 || bus.cpu_reset_ !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: done=%b cpu_reset_=%b, want 0 0", bus.ld_done,
                     bus.cpu_reset_);
        end
        bus.ld_len   = 12'd1;
        bus.ld_start = 1'b1;
        bus.run_req  = 1'b1;
        step();
        bus.ld_start = 1'b0;
        bus.run_req  = 1'b0;
        vectors++;
        if (bus.ld_ready !== 1'b1 || bus.cpu_reset_ !== 1'b0) begin
            errors++;
            $display("FAIL priority: ready=%b cpu_reset_=%b, want 1 0", bus.ld_ready,
                     bus.cpu_reset_);
        end
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = e[i];
            step();
            model_mem[i] = e[i];
        end
        bus.ld_valid = 1'b0;
        vectors++;
        if (bus.ld_done !== 1'b1 || bus.ld_csum !== 8'hF1) begin
            errors++;
            $display("FAIL reload_done: done=%b csum=%h, want 1 F1", bus.ld_done, bus.ld_csum);
        end
        step();
        for (int a = 0; a < 3; a++) begin
            bus.inst_addr = 12'(a);
            step();
            vectors++;
            if (bus.inst_data !== model_mem[a]) begin
                errors++;
                $display("FAIL reload_fetch addr %0d: got %h, want %h", a, bus.inst_data,
                         model_mem[a]);
            end
        end
        apply_reset(2);
        bus.run_req = 1'b1;
        step();
        bus.run_req = 1'b0;
        vectors++;
        if (bus.cpu_reset_ !== 1'b1 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_req: cpu_reset_=%b ready=%b, want 1 0", bus.cpu_reset_,
                     bus.ld_ready);
        end
        bus.ld_start  = 1'b1;
        bus.inst_addr = 12'd0;
        step();
        bus.ld_start = 1'b0;
        vectors++;
        if (bus.ld_ready !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_data !== model_mem[0]) begin
            errors++;
            $display("FAIL run_ignores_start: ready=%b valid=%b data=%h, want 0 1 %h",
                     bus.ld_ready, bus.inst_valid, bus.inst_data, model_mem[0]);
        end
        apply_reset(2);
    endtask

    task automatic test_random_load();
        logic [7:0] q[$];
        logic [7:0] exp_csum = 8'h00;
        int len_m1, rm, ed;
        logic dp, ca, cf;
        logic [7:0] cs;
        logic [11:0] a;
        len_m1 = int'($urandom_range(4, 60));
        for (int i = 0; i <= len_m1; i++) begin
            q.push_back(8'($urandom));
            exp_csum = exp_csum + q[i];
        end
        load_stream(len_m1, q, 3, rm, ed, dp, cs, ca, cf);
        vectors++;
        if (rm != 0 || ed != 0 || dp !== 1'b1 || cf !== 1'b1) begin
            errors++;
            $display("FAIL rand_load: ready_miss=%0d early=%0d done=%b cpu=%b, want 0 0 1 1",
                     rm, ed, dp, cf);
        end
        vectors++;
        if (cs !== exp_csum) begin
            errors++;
            $display("FAIL rand_csum: got %h, want %h", cs, exp_csum);
        end
        for (int i = 0; i < 24; i++) begin
            a = 12'($urandom_range(0, len_m1));
            bus.inst_addr = a;
            step();
            vectors++;
            if (bus.inst_valid !== 1'b1 || bus.inst_data !== model_mem[a]) begin
                errors++;
                $display("FAIL rand_fetch addr %h: got valid=%b data=%h, want 1 %h", a,
                         bus.inst_valid, bus.inst_data, model_mem[a]);
            end
        end
        apply_reset(2);
    endtask

    task automatic test_full_wrap();
        logic [7:0] q[$];
        int rm, ed;
        logic dp, ca, cf;
        logic [7:0] cs;
        logic [11:0] a;
        for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
        load_stream(DEPTH - 1, q, 0, rm, ed, dp, cs, ca, cf);
        vectors++;
        if (rm != 0 || ed != 0 || dp !== 1'b1 || cf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load: ready_miss=%0d early=%0d done=%b cpu=%b, want 0 0 1 1",
                     rm, ed, dp, cf);
        end
        vectors++;
        if (cs !== 8'h00) begin
            errors++;
            $display("FAIL wrap_csum: got %h, want 00", cs);
        end
        for (int i = 0; i < 18; i++) begin
            a = (i == 0) ? 12'hFFF : (i == 1) ? 12'h000 : 12'($urandom);
            bus.inst_addr = a;
            step();
            vectors++;
            if (bus.inst_valid !== 1'b1 || bus.inst_data !== a[7:0]) begin
                errors++;
                $display("FAIL wrap_fetch addr %h: got valid=%b data=%h, want 1 %h", a,
                         bus.inst_valid, bus.inst_data, a[7:0]);
            end
        end
        apply_reset(2);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_small_load();
        test_fetch();
        test_stalled();
        test_abort_priority();
        test_random_load();
        test_full_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
